// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: stall and forwarding control for the 5-stage F/D/E/M/W pipeline.
// Tags and Tuse/Tnew for the D instruction are carried down an internal E/M/W tag
// pipeline, so the datapath only has to present the instruction currently in D.
// Build macro HAZARD_PERF_EN adds saturating stall_cnt / md_stall_cnt outputs.
module hazard_fwd_unit #(
  parameter int unsigned AW          = 5,
  parameter int unsigned TW          = 2,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic [TW-1:0] tuse_rs_d,
  input  logic [TW-1:0] tuse_rt_d,
  input  logic [AW-1:0] a3_d,
  input  logic [TW-1:0] tnew_d,
  input  logic          md_start_d,
  input  logic          md_div_d,
  input  logic          md_use_d,
  output logic          stall,
  output logic [1:0]    rsd_sel,
  output logic [1:0]    rtd_sel,
  output logic [1:0]    rse_sel,
  output logic [1:0]    rte_sel,
  output logic [1:0]    rtm_sel,
  output logic          md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   md_stall_cnt
`endif
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW        = $clog2(MaxCycles + 1);
  localparam logic [TW-1:0] TuseNone = '1;

  // Tnew countdown: saturates at zero.
  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
    return (v == '0) ? v : v - TW'(1);
  endfunction

  // Tuse countdown: all-ones means "not used" and is sticky.
  function automatic logic [TW-1:0] dec_tuse(input logic [TW-1:0] v);
    return (v == TuseNone) ? v : dec_sat(v);
  endfunction

  // Nearest matching producer wins; a match that is not ready yet selects the
  // register file rather than an older (stale) stage.
  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] src,
    input logic          chk_e,
    input logic [AW-1:0] a3e,
    input logic [TW-1:0] tne,
    input logic          chk_m,
    input logic [AW-1:0] a3m,
    input logic [TW-1:0] tnm,
    input logic [AW-1:0] a3w,
    input logic [TW-1:0] tnw
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (chk_e && (a3e != '0) && (a3e == src)) begin
      sel = (tne == '0) ? 2'd3 : 2'd0;
    end else if (chk_m && (a3m != '0) && (a3m == src)) begin
      sel = (tnm == '0) ? 2'd2 : 2'd0;
    end else if ((a3w != '0) && (a3w == src)) begin
      sel = (tnw == '0) ? 2'd1 : 2'd0;
    end
    return sel;
  endfunction

  // Stage registers
  logic [AW-1:0] r_a3_e, r_rs_e, r_rt_e, r_a3_m, r_rs_m, r_rt_m, r_a3_w;
  logic [TW-1:0] r_tnew_e, r_tuse_rs_e, r_tuse_rt_e;
  logic [TW-1:0] r_tnew_m, r_tuse_rs_m, r_tuse_rt_m, r_tnew_w;
  logic [CW-1:0] r_md_cnt;

  // Next-state wires
  logic [AW-1:0] w_a3_e, w_rs_e, w_rt_e, w_a3_m, w_rs_m, w_rt_m, w_a3_w;
  logic [TW-1:0] w_tnew_e, w_tuse_rs_e, w_tuse_rt_e;
  logic [TW-1:0] w_tnew_m, w_tuse_rs_m, w_tuse_rt_m, w_tnew_w;
  logic [CW-1:0] w_md_cnt;

  logic w_rs_hazard, w_rt_hazard, w_lu_stall, w_md_stall, w_advance;

  // Tuse/rs in M are carried for completeness but nothing downstream reads them.
  logic w_unused_m;
  assign w_unused_m = ^{r_rs_m, r_tuse_rs_m, r_tuse_rt_m};

  // Stall terms: load-use against E/M producers, and HI/LO access while busy.
  always_comb begin
    w_rs_hazard = (rs_d != '0) && (tuse_rs_d != TuseNone) &&
                  (((rs_d == r_a3_e) && (r_tnew_e > tuse_rs_d)) ||
                   ((rs_d == r_a3_m) && (r_tnew_m > tuse_rs_d)));
    w_rt_hazard = (rt_d != '0) && (tuse_rt_d != TuseNone) &&
                  (((rt_d == r_a3_e) && (r_tnew_e > tuse_rt_d)) ||
                   ((rt_d == r_a3_m) && (r_tnew_m > tuse_rt_d)));
    w_lu_stall  = w_rs_hazard || w_rt_hazard;
    w_md_stall  = d_valid && md_use_d && md_busy;
    stall       = w_lu_stall || w_md_stall;
    w_advance   = d_valid && !stall;
  end

  // Forward selects for the D, E and M consumers.
  always_comb begin
    rsd_sel = fwd_sel(rs_d, 1'b1, r_a3_e, r_tnew_e, 1'b1, r_a3_m, r_tnew_m, r_a3_w, r_tnew_w);
    rtd_sel = fwd_sel(rt_d, 1'b1, r_a3_e, r_tnew_e, 1'b1, r_a3_m, r_tnew_m, r_a3_w, r_tnew_w);
    rse_sel = fwd_sel(r_rs_e, 1'b0, r_a3_e, r_tnew_e, 1'b1, r_a3_m, r_tnew_m, r_a3_w, r_tnew_w);
    rte_sel = fwd_sel(r_rt_e, 1'b0, r_a3_e, r_tnew_e, 1'b1, r_a3_m, r_tnew_m, r_a3_w, r_tnew_w);
    rtm_sel = fwd_sel(r_rt_m, 1'b0, r_a3_e, r_tnew_e, 1'b0, r_a3_m, r_tnew_m, r_a3_w, r_tnew_w);
    md_busy = (r_md_cnt != '0);
  end

  // Tag pipeline advance: E takes D (or a bubble), M and W always shift.
  always_comb begin
    w_a3_e      = '0;
    w_tnew_e    = '0;
    w_rs_e      = '0;
    w_rt_e      = '0;
    w_tuse_rs_e = TuseNone;
    w_tuse_rt_e = TuseNone;
    if (w_advance) begin
      w_a3_e      = a3_d;
      w_tnew_e    = tnew_d;
      w_rs_e      = rs_d;
      w_rt_e      = rt_d;
      w_tuse_rs_e = tuse_rs_d;
      w_tuse_rt_e = tuse_rt_d;
    end
    w_a3_m      = r_a3_e;
    w_tnew_m    = dec_sat(r_tnew_e);
    w_rs_m      = r_rs_e;
    w_rt_m      = r_rt_e;
    w_tuse_rs_m = dec_tuse(r_tuse_rs_e);
    w_tuse_rt_m = dec_tuse(r_tuse_rt_e);
    w_a3_w      = r_a3_m;
    w_tnew_w    = dec_sat(r_tnew_m);
  end

  // HI/LO busy counter: loaded when a mult/div leaves D, then counts down.
  always_comb begin
    w_md_cnt = r_md_cnt;
    if (w_advance && md_start_d) begin
      w_md_cnt = md_div_d ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (r_md_cnt != '0) begin
      w_md_cnt = r_md_cnt - CW'(1);
    end
  end

  // State registers; reset leaves a bubble in every stage and an idle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a3_e      <= '0;
      r_tnew_e    <= '0;
      r_rs_e      <= '0;
      r_rt_e      <= '0;
      r_tuse_rs_e <= TuseNone;
      r_tuse_rt_e <= TuseNone;
      r_a3_m      <= '0;
      r_tnew_m    <= '0;
      r_rs_m      <= '0;
      r_rt_m      <= '0;
      r_tuse_rs_m <= TuseNone;
      r_tuse_rt_m <= TuseNone;
      r_a3_w      <= '0;
      r_tnew_w    <= '0;
      r_md_cnt    <= '0;
    end else begin
      r_a3_e      <= w_a3_e;
      r_tnew_e    <= w_tnew_e;
      r_rs_e      <= w_rs_e;
      r_rt_e      <= w_rt_e;
      r_tuse_rs_e <= w_tuse_rs_e;
      r_tuse_rt_e <= w_tuse_rt_e;
      r_a3_m      <= w_a3_m;
      r_tnew_m    <= w_tnew_m;
      r_rs_m      <= w_rs_m;
      r_rt_m      <= w_rt_m;
      r_tuse_rs_m <= w_tuse_rs_m;
      r_tuse_rt_m <= w_tuse_rt_m;
      r_a3_w      <= w_a3_w;
      r_tnew_w    <= w_tnew_w;
      r_md_cnt    <= w_md_cnt;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt, r_md_stall_cnt;

  // Saturating performance counters; md_stall_cnt only counts pure HI/LO stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt    <= '0;
      r_md_stall_cnt <= '0;
    end else begin
      if (stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_md_stall && !w_lu_stall && (r_md_stall_cnt != '1)) begin
        r_md_stall_cnt <= r_md_stall_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt    = r_stall_cnt;
  assign md_stall_cnt = r_md_stall_cnt;
`endif

endmodule
